// File: rtl/mem_burst_master_pkg.sv
// Shared types and constants for the burst master and its read FIFO.
//   state_e        : controller state (IDLE / WRITE / READ / DONE)
//   RD_FIFO_DEPTH  : read-data buffer depth; also the read-ahead limit
package mem_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_e;

    localparam int unsigned RD_FIFO_DEPTH = 2;

endpackage

// File: rtl/mem_burst_master_if.sv
// Bundle of the command, write-stream, read-stream, status and RAM signals of the burst master.
//   master modport : the burst master's view (drives ready/valid outputs and the RAM port)
//   slave modport  : the environment's view (command source, data source/sink and the RAM)
interface mem_burst_master_if #(
    parameter int unsigned ADDR       = 5,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR-1:0]       cmd_addr;
    logic [ADDR:0]         cmd_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  done;
    logic                  busy;
    logic                  mem_r_w;
    logic [ADDR-1:0]       mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_dout,
        output cmd_ready, wr_ready, rd_valid, rd_data, done, busy, mem_r_w, mem_addr, mem_din
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_dout,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done, busy, mem_r_w, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_burst_master_rd_skid_fifo.sv
// Two-entry read-data FIFO with a registered head.
//   clk, rst_n    : clock, asynchronous active-low reset (empties the FIFO, head reads 0)
//   push_i/data_i : write one word
//   pop_i         : drop the head word (never asserted when empty)
//   count_o       : number of stored words
//   head_o        : oldest word, straight from a register
module rd_skid_fifo
    import mem_burst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    localparam int unsigned CntW      = $clog2(RD_FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [CntW-1:0]       count_o,
    output logic [DATA_WIDTH-1:0] head_o
);
    localparam logic [CntW-1:0] CntOne = 1;

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (count_q == '0) head_d = push_data_i;
                else               tail_d = push_data_i;
                count_d = count_q + CntOne;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - CntOne;
            end
            2'b11: begin
                // Count unchanged; the new word lands behind whatever survives the pop.
                if (count_q == CntOne) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port synchronous RAM with 1-cycle registered read data.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any burst, no done pulse)
//   bus        : cmd_* command handshake, wr_* write stream in, rd_* read stream out,
//                done/busy status, mem_* RAM port
// Write bursts forward each accepted beat to the RAM in the same cycle. Read bursts issue
// at most two reads ahead of the sink and buffer the returning words in rd_skid_fifo.
module mem_burst_master
    import mem_burst_pkg::*;
#(
    parameter int unsigned ADDR       = 5,
    parameter int unsigned DATA_WIDTH = 64
) (
    input logic              clk,
    input logic              rst_n,
    mem_burst_master_if.master bus
);
    localparam int unsigned   CntW   = $clog2(RD_FIFO_DEPTH + 1);
    localparam logic [ADDR:0] MaxLen = {1'b1, {ADDR{1'b0}}};

    state_e                state_q, state_d;
    logic [ADDR-1:0]       addr_q, addr_d;
    logic [ADDR:0]         issue_cnt_q, issue_cnt_d;
    logic [ADDR:0]         pop_cnt_q, pop_cnt_d;
    logic                  inflight_q;
    logic [ADDR:0]         len_eff;
    logic                  accept, wr_beat, rd_valid, pop, issue;
    logic [CntW-1:0]       fifo_count;
    logic [CntW:0]         occupancy;
    logic [DATA_WIDTH-1:0] fifo_head;

    assign len_eff  = (bus.cmd_len > MaxLen) ? MaxLen : bus.cmd_len;
    assign accept   = (state_q == IDLE) && bus.cmd_valid;
    assign wr_beat  = (state_q == WRITE) && bus.wr_valid;
    assign rd_valid = (state_q == READ) && (fifo_count != '0);
    assign pop      = rd_valid && bus.rd_ready;

    // Words that will be buffered after this cycle: stored + returning - leaving.
    assign occupancy = (CntW + 1)'(fifo_count) + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
    assign issue     = (state_q == READ) && (issue_cnt_q != '0)
                     && (occupancy < (CntW + 1)'(RD_FIFO_DEPTH));

    rd_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (bus.mem_dout),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (len_eff == '0)     state_d = DONE;
                    else if (bus.cmd_write) state_d = WRITE;
                    else                    state_d = READ;
                end
            end
            WRITE:   if (wr_beat && issue_cnt_q == (ADDR + 1)'(1)) state_d = DONE;
            READ:    if (pop && pop_cnt_q == (ADDR + 1)'(1))       state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.cmd_ready = (state_q == IDLE);
        bus.wr_ready  = (state_q == WRITE);
        bus.rd_valid  = rd_valid;
        bus.rd_data   = fifo_head;
        bus.done      = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.mem_r_w   = wr_beat;
        bus.mem_addr  = addr_q;
        bus.mem_din   = (state_q == WRITE) ? bus.wr_data : '0;
    end

    // Burst address and counters
    always_comb begin
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        if (accept) begin
            addr_d      = bus.cmd_addr;
            issue_cnt_d = len_eff;
            pop_cnt_d   = len_eff;
        end
        if (wr_beat || issue) begin
            addr_d      = addr_q + ADDR'(1);
            issue_cnt_d = issue_cnt_q - (ADDR + 1)'(1);
        end
        if (pop) pop_cnt_d = pop_cnt_q - (ADDR + 1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            inflight_q  <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            inflight_q  <= issue;
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: behavioural RAM plus a word-level reference memory that
// predicts every RAM write and every read-stream word.
module tb_mem_burst_master;
    localparam int unsigned ADDR  = 5;
    localparam int unsigned DW    = 64;
    localparam int          DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] pat     [4];

    mem_burst_master_if #(.ADDR(ADDR), .DATA_WIDTH(DW)) bus ();

    mem_burst_master #(
        .ADDR       (ADDR),
        .DATA_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read-first, registered dout; not affected by reset.
    always @(posedge clk) begin
        if (bus.mem_r_w) ram[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= ram[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic junk_cmd();
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr  = ADDR'($urandom);
        bus.cmd_len   = (ADDR + 1)'($urandom);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_wr_ready"},  bus.wr_ready,  0);
        chk({tag, "_rd_valid"},  bus.rd_valid,  0);
        chk({tag, "_rd_data"},   bus.rd_data,   0);
        chk({tag, "_done"},      bus.done,      0);
        chk({tag, "_busy"},      bus.busy,      0);
        chk({tag, "_mem_r_w"},   bus.mem_r_w,   0);
        chk({tag, "_mem_addr"},  bus.mem_addr,  0);
        chk({tag, "_mem_din"},   bus.mem_din,   0);
    endtask

    task automatic do_write(input int a, input int len, input bit gaps, input bit use_pat);
        int            eff   = (len > DEPTH) ? DEPTH : len;
        int            beats = 0;
        int            cyc   = 0;
        logic [DW-1:0] d;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = ADDR'(a);
        bus.cmd_len   = (ADDR + 1)'(len);
        #1;
        chk("wr_cmd_ready", bus.cmd_ready, 1);
        while (beats < eff && cyc < 4 * DEPTH + 16) begin
            @(negedge clk);
            junk_cmd();
            bus.wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            d = use_pat ? pat[beats % 4] : {$urandom, $urandom};
            bus.wr_data = d;
            #1;
            chk("wr_ready", bus.wr_ready, 1);
            chk("wr_cmd_ready_busy", bus.cmd_ready, 0);
            chk("wr_mem_r_w", bus.mem_r_w, bus.wr_valid);
            chk("wr_mem_din", bus.mem_din, d);
            if (bus.wr_valid) begin
                chk("wr_mem_addr", bus.mem_addr, (a + beats) % DEPTH);
                ref_mem[(a + beats) % DEPTH] = d;
                beats++;
            end
            cyc++;
        end
        if (beats < eff) chk("wr_timeout", beats, eff);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        #1;
        chk("wr_done_pulse", bus.done, 1);
        chk("wr_done_busy", bus.busy, 1);
        chk("wr_done_wr_ready", bus.wr_ready, 0);
        chk("wr_done_mem_r_w", bus.mem_r_w, 0);
        chk("wr_done_mem_din", bus.mem_din, 0);
        @(negedge clk);
        #1;
        chk("wr_done_low", bus.done, 0);
        chk("wr_cmd_ready_back", bus.cmd_ready, 1);
    endtask

    // mode 0: sink always ready; 1: ready 1,0,0 repeating; 2: random ready.
    // abort_after > 0 asserts reset once that many words have been popped.
    task automatic do_read(input int a, input int len, input int mode, input int abort_after);
        int              eff    = (len > DEPTH) ? DEPTH : len;
        int              pops   = 0;
        int              issues = 0;
        int              cyc    = 0;
        int              first  = -1;
        bit              held_v = 1'b0;
        bit              aborted = 1'b0;
        logic [DW-1:0]   held_d = '0;
        logic [ADDR-1:0] prev_addr = ADDR'(a);
        logic [DW-1:0]   exp_q[$];
        for (int i = 0; i < eff; i++) exp_q.push_back(ref_mem[(a + i) % DEPTH]);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = ADDR'(a);
        bus.cmd_len   = (ADDR + 1)'(len);
        bus.rd_ready  = 1'b0;
        #1;
        chk("rd_cmd_ready", bus.cmd_ready, 1);
        while (pops < eff && cyc < 8 * DEPTH + 32 && !aborted) begin
            @(negedge clk);
            junk_cmd();
            case (mode)
                0:       bus.rd_ready = 1'b1;
                1:       bus.rd_ready = (cyc % 3 == 0);
                default: bus.rd_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk("rd_cmd_ready_busy", bus.cmd_ready, 0);
            chk("rd_wr_ready", bus.wr_ready, 0);
            chk("rd_mem_r_w", bus.mem_r_w, 0);
            chk("rd_mem_din", bus.mem_din, 0);
            if (bus.mem_addr != prev_addr) begin
                issues++;
                prev_addr = bus.mem_addr;
            end
            chk("rd_mem_addr", bus.mem_addr, (a + issues) % DEPTH);
            chk("rd_ahead_le2", (issues - pops) <= 2, 1);
            if (held_v) begin
                chk("rd_valid_hold", bus.rd_valid, 1);
                chk("rd_data_hold", bus.rd_data, held_d);
            end
            if (bus.rd_valid) begin
                if (first < 0) first = cyc;
                chk("rd_data", bus.rd_data, exp_q[pops]);
                if (bus.rd_ready) begin
                    pops++;
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held_d = bus.rd_data;
                end
            end
            cyc++;
            if (abort_after > 0 && pops == abort_after) aborted = 1'b1;
        end
        if (aborted) begin
            @(negedge clk);
            rst_n         = 1'b0;
            bus.cmd_valid = 1'b0;
            #1;
            chk_reset_outputs("abort");
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk_reset_outputs("abort_rel");
        end else begin
            if (pops < eff) chk("rd_timeout", pops, eff);
            chk("rd_issue_total", issues, eff);
            if (mode == 0 && eff > 0) begin
                chk("rd_first_latency", first, 2);
                chk("rd_streaming_cycles", cyc, eff + 2);
            end
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.rd_ready  = 1'($urandom_range(0, 1));
            #1;
            chk("rd_done_pulse", bus.done, 1);
            chk("rd_done_rd_valid", bus.rd_valid, 0);
            @(negedge clk);
            #1;
            chk("rd_done_low", bus.done, 0);
            chk("rd_idle_rd_valid", bus.rd_valid, 0);
            chk("rd_cmd_ready_back", bus.cmd_ready, 1);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;
        pat[0] = 64'h11;
        pat[1] = 64'h22;
        pat[2] = 64'h33;
        pat[3] = 64'h44;
        #1;
        chk_reset_outputs("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        do_write(0, 4, 1'b0, 1'b1);
        do_read(0, 4, 0, 0);
        do_write(5, 40, 1'b1, 1'b0);   // saturates to 32 beats, fills the whole RAM
        do_read(0, 32, 0, 0);
        do_write(7, 0, 1'b0, 1'b0);
        do_read(9, 0, 0, 0);
        do_write(30, 4, 1'b0, 1'b0);
        do_read(30, 4, 0, 0);
        do_read(3, 8, 1, 0);
        do_read(int'($urandom_range(0, DEPTH - 1)), 32, 2, 0);
        do_write(int'($urandom_range(0, DEPTH - 1)), 12, 1'b1, 1'b0);
        do_read(12, 40, 2, 0);
        do_read(20, 8, 0, 3);
        do_read(20, 8, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Initiator side of the single-port synchronous RAM interface (clk, r_w, addr, din, dout) used across the crypto datapaths.
- Accepts one burst command at a time: a write burst streams words from a valid/ready source into the RAM; a read burst streams RAM words out through valid/ready with full backpressure.
- Compensates for the RAM's 1-cycle registered read latency.
- Sits between cipher cores (key schedule, block buffers) and the RAM instance.

Parameters:
ADDR, 5, RAM address width; depth 2**ADDR
DATA_WIDTH, 64, word width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  controller idle, command accepted when cmd_valid&&cmd_ready
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR  start address
cmd_len  in  ADDR+1  word count; 0 = no-op; values >2**ADDR saturate to 2**ADDR
wr_valid  in  1  write-data beat valid
wr_ready  out  1  write-data beat accepted
wr_data  in  DATA_WIDTH  write data
rd_valid  out  1  read-data beat valid
rd_ready  in  1  read-data sink ready
rd_data  out  DATA_WIDTH  read data
done  out  1  one-cycle pulse at burst completion
busy  out  1  state != IDLE
mem_r_w  out  1  to RAM r_w (1=write)
mem_addr  out  ADDR  to RAM addr
mem_din  out  DATA_WIDTH  to RAM din
mem_dout  in  DATA_WIDTH  from RAM dout

Behaviour:
- Reset (rst_n=0, async): state IDLE, address/counters 0, FIFO emptied, in-flight flag cleared. Outputs: cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, done=0, busy=0, mem_r_w=0, mem_addr=0, mem_din=0.
- Reset mid-burst aborts immediately. In-flight and buffered read data is discarded. RAM contents are untouched. No done pulse.
- States:
  - IDLE. On accept: len_eff=0 goes to DONE. cmd_write=1 goes to WRITE. Otherwise goes to READ. Latch addr_q=cmd_addr, issue_cnt=len_eff, pop_cnt=len_eff.
  - WRITE. wr_ready=1. mem_r_w=wr_valid, mem_addr=addr_q, mem_din=wr_data (combinational). Each accepted beat writes in the same cycle, addr_q+1, issue_cnt-1. Last beat goes to DONE.
  - READ. mem_r_w=0, mem_addr=addr_q. A read issues when issue_cnt>0 and (fifo_count + inflight - pop) < 2, where pop=rd_valid&&rd_ready. On issue: addr_q+1, issue_cnt-1, inflight<=1. The cycle after an issue, mem_dout is pushed into the FIFO. Each pop decrements pop_cnt. The pop that takes pop_cnt to 0 goes to DONE.
  - DONE. done=1 for exactly one cycle, then IDLE.
- In all states other than WRITE: mem_r_w=0 and mem_din=0. Outside WRITE/READ, mem_addr holds addr_q.
- Address wraps modulo 2**ADDR. Example: start 30, len 4 gives addresses 30, 31, 0, 1.
- Read latency: read issued in cycle t, FIFO push in t+1, rd_valid in t+2. With rd_ready held high, throughput is 1 word/cycle after the first word.
- Backpressure: with rd_ready=0, at most 2 words are issued ahead. rd_data is held stable while rd_valid&&!rd_ready.
- Write throughput: 1 word/cycle while wr_valid=1. wr_valid gaps stall with no effect on the RAM.
- cmd_valid while busy is ignored (cmd_ready=0). cmd_* inputs are sampled only at accept.
- wr_ready=0 outside WRITE. rd_valid is never asserted outside READ, including after the last pop.

Decomposition:
- Package mem_burst_pkg:
  - state enum {IDLE, WRITE, READ, DONE}
  - FIFO depth constant RD_FIFO_DEPTH=2
- Sub-module rd_skid_fifo: 2-entry DATA_WIDTH FIFO with push, pop, count, registered head output, async active-low reset.

Test Plan:
- Write burst addr 0, len 4, data 0x11..0x44, wr_valid held high -> mem_r_w=1 for 4 consecutive cycles at addresses 0..3; done pulses the cycle after the 4th beat; cmd_ready returns 1.
- Read burst addr 0, len 4, rd_ready=1 -> rd_valid first high 2 cycles after the first issue; then 0x11, 0x22, 0x33, 0x44 on consecutive cycles; single done pulse.
- Wrap: write addr 30, len 4, data A..D, then read addr 30, len 4 -> RAM addresses 30, 31, 0, 1; read data A, B, C, D in order.
- Backpressure: read len 8 with rd_ready toggled 1,0,0,1,... -> no word lost or duplicated; at most 2 issues ahead of pops; rd_data stable while stalled.
- Edge lengths: len 0 -> done next cycle, no RAM write; len 40 with ADDR=5 -> exactly 32 beats.
- Reset mid-read (rst_n low after 3 pops of 8) -> all outputs at reset values immediately; a new read burst afterwards returns correct data.
